// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants, default clocking
// and the even-parity helper. The receiver path uses this package as well.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int DEF_CLK_HZ = 12_000_000;
    localparam int DEF_BAUD   = 9600;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic uart_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through read port. rd_data always
// shows the head entry. Pushes while full and pops while empty are ignored.
// DEPTH must be a power of two so that the pointers wrap on their own.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Next pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer and count registers. Reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array. It needs no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter. Bytes from a valid/ready port are queued in a FIFO
// and sent LSB-first as 8N1 frames at CLK_HZ/BAUD clocks per bit.
// Define UART_TX_PARITY_EN to add an even-parity bit between data and stop (8E1).
// The line output is registered, so the serial waveform lags the FSM state by one cycle.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        baud_q,  baud_d;
    logic [2:0]           bit_q,   bit_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 uart_tx_q, uart_tx_d;

    logic                 fifo_rd_en;
    logic [7:0]           fifo_rd_data;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 bit_done;

    // tx_ready is held low during reset so that no byte is taken while the FIFO is being cleared.
    assign tx_ready = !rst && !fifo_full;
    assign uart_tx  = uart_tx_q;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign bit_done = (baud_q == BW'(DIV - 1));

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid && tx_ready),
        .wr_data (tx_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Frame sequencing. Each state holds for DIV cycles, and the line level follows the current state.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + 1'b1;
        bit_d      = bit_q;
        data_d     = data_q;
        fifo_rd_en = 1'b0;
        uart_tx_d  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    data_d     = fifo_rd_data;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                uart_tx_d = 1'b0;
                if (bit_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                uart_tx_d = data_q[bit_q];
                if (bit_done) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                uart_tx_d = uart_parity(data_q);
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    // Go straight into the next start bit when a byte is waiting, so no idle gap appears.
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        data_d     = fifo_rd_data;
                        state_d    = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, shifter and line register. Reset drives the line high on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            uart_tx_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            uart_tx_q <= uart_tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a mid-bit loopback decoder and a byte scoreboard.
// It runs at DIV=16 to keep the run short. Define UART_TX_PARITY_EN to match a parity build.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 153_600;
    localparam int BAUD   = 9600;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, uart_tx, busy;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    int         starts[$];
    bit         dec_en = 1'b0;

    uart_tx_buffered #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_tx  (uart_tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge. Returns at the negedge after the accepting edge, with acc set to that edge's index.
    task automatic send(input logic [7:0] b, input bit score, output int acc);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        acc      = cyc;
        tx_valid = 1'b0;
        if (score) sb.push_back(b);
    endtask

    task automatic run_len(input logic lvl, input int lim, output int n);
        n = 0;
        while (uart_tx === lvl && n < lim) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || sb.size() != 0) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < lim), 32'd1);
    endtask

    // Loopback receiver: finds each start bit, samples mid-bit, and checks the byte against the scoreboard.
    initial begin : decoder
        logic       prev;
        logic [7:0] b;
        wait (dec_en);
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !uart_tx) begin
                starts.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                chk("rx_start", 32'(uart_tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (DIV) @(negedge clk);
                chk("rx_parity", 32'(uart_tx), 32'(^b));
`endif
                repeat (DIV) @(negedge clk);
                chk("rx_stop", 32'(uart_tx), 32'd1);
                chk("rx_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) chk("rx_byte", 32'(b), 32'(sb.pop_front()));
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin : stim
        int a, b2, c, n, k, sidx, nacc, first_block, acc1, acc6, lim;

        // Reset state, then a reset in the middle of a frame with a second byte still queued.
        repeat (3) @(negedge clk);
        chk("rst_line", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(tx_ready), 32'd1);
        send(8'h55, 1'b0, a);
        send(8'hAA, 1'b0, a);
        repeat (3 * DIV) @(negedge clk);
        chk("busy_midframe", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_line", 32'(uart_tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(tx_ready), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("hold_ready", 32'(tx_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("release_ready", 32'(tx_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        run_len(1'b1, 2 * DIV, n);
        chk("discard_idle", 32'(n), 32'(2 * DIV));
        chk("discard_busy", 32'(busy), 32'd0);
        dec_en = 1'b1;

        // Single 0x01: check the falling-edge latency and the run lengths on the line.
        send(8'h01, 1'b1, a);
        k = 0;
        while (uart_tx === 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("fall_latency", 32'(k), 32'd2);
        run_len(1'b0, 4 * DIV, n);
        chk("start_len", 32'(n), 32'(DIV));
        run_len(1'b1, 4 * DIV, n);
        chk("bit0_len", 32'(n), 32'(DIV));
        run_len(1'b0, 10 * DIV, n);
        chk("bits71_len", 32'(n), 32'(7 * DIV));
        run_len(1'b1, 3 * DIV, n);
        chk("stop_high", 32'(n >= DIV), 32'd1);
        wait_idle(4 * FRAME);

        // 'h' (0x68): busy stays high for the pop cycle plus one whole frame.
        send(8'h68, 1'b1, a);
        n = 0;
        while (busy && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("frame_len", 32'(n), 32'(1 + FRAME));
        wait_idle(4 * FRAME);

        // Burst 0x01..0x06 with tx_valid held high.
        sidx        = starts.size();
        nacc        = 0;
        first_block = -1;
        acc1        = 0;
        acc6        = 0;
        lim         = 0;
        tx_data     = 8'h01;
        tx_valid    = 1'b1;
        while (nacc < 6 && lim < 4 * FRAME) begin
            if (tx_ready) begin
                @(negedge clk);
                nacc++;
                sb.push_back(tx_data);
                if (nacc == 1) acc1 = cyc;
                if (nacc == 6) begin
                    acc6     = cyc;
                    tx_valid = 1'b0;
                end else begin
                    tx_data = 8'(nacc + 1);
                end
            end else begin
                if (first_block < 0) first_block = nacc;
                @(negedge clk);
            end
            lim++;
        end
        tx_valid = 1'b0;
        chk("burst_accepted", 32'(nacc), 32'd6);
        chk("burst_before_full", 32'(first_block), 32'd5);
        chk("burst_6th_time", 32'(acc6 - acc1), 32'(FRAME + 2));
        wait_idle(10 * FRAME);
        chk("burst_frames", 32'(starts.size() - sidx), 32'd6);
        for (int i = 0; i < 5; i++)
            if (sidx + i + 1 < starts.size())
                chk("burst_gap", 32'(starts[sidx+i+1] - starts[sidx+i]), 32'(FRAME));

        // Push coinciding with the last stop cycle while one byte is queued.
        sidx = starts.size();
        send(8'hA5, 1'b1, a);
        send(8'h3C, 1'b1, b2);
        chk("pp_second_acc", 32'(b2 - a), 32'd1);
        lim = 0;
        while (cyc < a + FRAME && lim < 4 * FRAME) begin
            @(negedge clk);
            lim++;
        end
        send(8'hC3, 1'b1, c);
        chk("pp_push_edge", 32'(c - a), 32'(1 + FRAME));
        wait_idle(6 * FRAME);
        chk("pp_frames", 32'(starts.size() - sidx), 32'd3);
        for (int i = 0; i < 2; i++)
            if (sidx + i + 1 < starts.size())
                chk("pp_gap", 32'(starts[sidx+i+1] - starts[sidx+i]), 32'(FRAME));

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_line", 32'(uart_tx), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
